// File: rtl/enigma_stream_ctrl.sv
// enigma_stream_ctrl
// Sequences one message through the external four-box substitution datapath.
// Characters arrive over a valid/ready handshake. Letters are held on the
// datapath for LAT cycles and the encoded result is presented downstream.
// Non-letters skip the datapath. The 2-bit setting advances like a rotor
// every STEP_PERIOD encoded letters.
module enigma_stream_ctrl #(
   parameter int unsigned LAT         = 2,
   parameter int unsigned STEP_PERIOD = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  key_init,
   input  logic        abort,
   input  logic        in_valid,
   input  logic [7:0]  in_char,
   input  logic        in_last,
   output logic        in_ready,
   output logic [7:0]  dp_char,
   output logic [1:0]  dp_setting,
   input  logic [7:0]  dp_result,
   output logic        out_valid,
   output logic [7:0]  out_char,
   input  logic        out_ready,
   output logic        busy,
   output logic        done,
   output logic [15:0] letter_cnt
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READY = 2'd1,
      DRIVE = 2'd2,
      HOLD  = 2'd3
   } state_t;

   localparam logic [3:0] LAT_LOAD  = 4'(LAT);
   localparam logic [3:0] STEP_LAST = 4'(STEP_PERIOD - 1);

   state_t      state;
   state_t      state_nxt;

   logic [3:0]  wait_cnt;
   logic        last_q;
   logic        byp_q;
   logic [1:0]  setting;
   logic [3:0]  step_cnt;
   logic [15:0] letter_q;
   logic [7:0]  out_char_q;
   logic [7:0]  dp_char_q;
   logic [1:0]  dp_setting_q;
   logic        done_q;

   logic        accept;
   logic        finish;
   logic        encode_done;
   logic        handoff;

   // Only upper-case ASCII letters are routed through the substitution boxes.
   function automatic logic is_letter(input logic [7:0] c);
      return (c >= 8'h41) && (c <= 8'h5A);
   endfunction

   // Rotor advance: 3 wraps back to 0.
   function automatic logic [1:0] next_setting(input logic [1:0] s);
      return s + 2'd1;
   endfunction

   assign accept      = (state == READY) && in_valid;
   assign finish      = (state == DRIVE) && (wait_cnt == 4'd1);
   assign encode_done = finish && !byp_q;
   assign handoff     = (state == HOLD) && out_ready;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; abort overrides every transition, including start in IDLE.
   always_comb begin
      state_nxt = state;
      if (abort) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (start)           state_nxt = READY;
            READY:   if (in_valid)        state_nxt = DRIVE;
            DRIVE:   if (wait_cnt == 4'd1) state_nxt = HOLD;
            HOLD: begin
               if (out_ready) state_nxt = last_q ? IDLE : READY;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Handshake and status outputs decoded straight from the state so that
   // reset clears them without waiting for a clock edge.
   always_comb begin
      in_ready  = (state == READY);
      out_valid = (state == HOLD);
      busy      = (state != IDLE);
   end

   // Character capture. A bypassed byte still spends one DRIVE cycle (wait=1)
   // so its output appears one cycle after accept; byp_q keeps that cycle from
   // touching the datapath result or the rotor.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt     <= 4'd0;
         last_q       <= 1'b0;
         byp_q        <= 1'b0;
         dp_char_q    <= 8'h00;
         dp_setting_q <= 2'd0;
      end else if (!abort) begin
         if (accept) begin
            last_q <= in_last;
            if (is_letter(in_char)) begin
               byp_q        <= 1'b0;
               wait_cnt     <= LAT_LOAD;
               dp_char_q    <= in_char;
               dp_setting_q <= setting;
            end else begin
               byp_q    <= 1'b1;
               wait_cnt <= 4'd1;
            end
         end else if (state == DRIVE) begin
            wait_cnt <= wait_cnt - 4'd1;
         end
      end
   end

   // Rotor state: loaded from the key on start, stepped after every
   // STEP_PERIOD encoded letters. Retained across abort.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         setting  <= 2'd0;
         step_cnt <= 4'd0;
         letter_q <= 16'd0;
      end else if (!abort) begin
         if ((state == IDLE) && start) begin
            setting  <= key_init;
            step_cnt <= 4'd0;
            letter_q <= 16'd0;
         end else if (encode_done) begin
            letter_q <= letter_q + 16'd1;
            if (step_cnt == STEP_LAST) begin
               step_cnt <= 4'd0;
               setting  <= next_setting(setting);
            end else begin
               step_cnt <= step_cnt + 4'd1;
            end
         end
      end
   end

   // Output character register: bypass bytes load on accept, letters load the
   // datapath result on the final DRIVE edge; stable throughout HOLD.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_char_q <= 8'h00;
      end else if (!abort) begin
         if (accept && !is_letter(in_char)) begin
            out_char_q <= in_char;
         end else if (encode_done) begin
            out_char_q <= dp_result;
         end
      end
   end

   // done pulses for one cycle after the final character's handoff edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         done_q <= 1'b0;
      end else begin
         done_q <= !abort && handoff && last_q;
      end
   end

   assign dp_char    = dp_char_q;
   assign dp_setting = dp_setting_q;
   assign out_char   = out_char_q;
   assign done       = done_q;
   assign letter_cnt = letter_q;

endmodule

// File: doc/enigma_stream_ctrl.md
# enigma_stream_ctrl

Sequencing controller for the four-box character substitution datapath. It accepts a message one character at a time over a valid/ready handshake and drives the datapath's character input and 2-bit setting. It waits a fixed settle latency, then presents the encoded character downstream. The setting steps like a rotor, advancing by one (mod 4) every STEP_PERIOD letters. Sender and receiver therefore only share a starting key and a period instead of a per-character setting.

## Interface
- LAT, 2: cycles from a change on dp_char/dp_setting until dp_result is valid; legal range 1..15.
- STEP_PERIOD, 5: letters encoded per setting value before the setting advances; legal range 1..15.

- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle pulse; begins a message. Honoured only in IDLE.
- key_init  in  2  starting setting, sampled on the start edge.
- abort  in  1  synchronous abort; returns the block to IDLE from any state.
- in_valid  in  1  upstream character valid.
- in_char  in  8  upstream ASCII character.
- in_last  in  1  marks the final character of the message; qualified by in_valid.
- in_ready  out  1  controller can accept a character.
- dp_char  out  8  character driven to the datapath.
- dp_setting  out  2  setting driven to the datapath.
- dp_result  in  8  datapath output.
- out_valid  out  1  encoded character available.
- out_char  out  8  encoded character.
- out_ready  in  1  downstream accepts out_char.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the last character is handed off.
- letter_cnt  out  16  letters encoded since start; wraps at 65535 -> 0.

## Operation
- FSM states: IDLE, READY, DRIVE, HOLD.
- IDLE behaviour:
  - in_ready=0.
  - On start: setting<=key_init, step_cnt<=0, letter_cnt<=0, then go to READY.
- READY behaviour:
  - in_ready=1.
  - On in_valid&in_ready: capture char and in_last.
  - Letters 'A'..'Z' (0x41..0x5A) go to DRIVE, with wait<=LAT.
  - Any other byte bypasses the datapath: out_char<=char, then HOLD. A bypassed byte does not count toward stepping.
- DRIVE behaviour:
  - dp_char=captured char and dp_setting=setting, held constant throughout DRIVE.
  - wait decrements once per edge.
  - On the edge where wait==1:
    - out_char<=dp_result and letter_cnt++.
    - If step_cnt==STEP_PERIOD-1: step_cnt<=0 and setting<=setting+1 (3 wraps to 0). Otherwise step_cnt++.
    - Go to HOLD.
- HOLD behaviour:
  - out_valid=1, with out_char stable until accepted.
  - On out_ready: if the captured last flag is set, pulse done and go to IDLE. Otherwise go to READY.
- start outside IDLE is ignored.
- abort: from any state, go to IDLE next edge, drop out_valid and in_ready, no done pulse. setting, step_cnt and letter_cnt are retained until the next start.
- If abort and start are both high in IDLE, abort wins: the block stays in IDLE.
- Reset values: state=IDLE, in_ready=0, out_valid=0, out_char=0x00, dp_char=0x00, dp_setting=0, setting=0, step_cnt=0, letter_cnt=0, busy=0, done=0.
- Outside DRIVE, dp_char and dp_setting hold their last driven values.

## Timing
- Letter latency: accept edge E -> out_valid high after edge E+LAT.
- Bypass latency: accept edge E -> out_valid high after edge E+1.
- Minimum spacing between accepts: LAT+2 cycles for letters, 3 cycles for bypass bytes (this includes one HOLD cycle with out_ready=1).
- in_ready and out_valid are never high in the same cycle.
- The new setting is first used by the letter after the one that triggered the step.
- done is asserted in the cycle after the final handshake edge, coincident with busy=0.
- rst asserted mid-DRIVE or mid-HOLD clears everything immediately, with no handshake completion.

## Test plan
- Step boundary: key_init=0, STEP_PERIOD=2, LAT=2, send "AAA" with out_ready=1 -> out_char O, O, X; letter_cnt=3; dp_setting=1 during the third DRIVE.
- Setting wrap: key_init=3, STEP_PERIOD=1, send "AA" -> F, then O (setting 3 wraps to 0).
- Bypass: key_init=0, STEP_PERIOD=1, send 'A',' ','A' -> O, 0x20, X. The space arrives 1 cycle after accept and causes no step.
- Backpressure: out_ready held 0 for 5 cycles during HOLD -> out_valid stays 1, out_char constant, in_ready stays 0. The handshake completes on the first out_ready=1 edge.
- End and ignore: start pulsed during READY is ignored. in_last set on the third char -> done pulses once and busy falls. A following start re-loads key_init.
- Abort and reset: abort in DRIVE -> IDLE next cycle, out_valid never rises, no done pulse. rst asserted mid-HOLD -> all outputs at reset values asynchronously, before the next clock edge.
